na_read_wb: RTL and testbench

- Egress counterpart of the DI write path in the NoC adapter bridge.
- Acts as a Wishbone master that polls the NI endpoints in round-robin order and reads one complete NoC packet (32-bit flits) from an endpoint.
- Emits the packet towards the debug interconnect as 16-bit dii_flit packets.
- Shares the endpoint Wishbone bus with the write path through a req/gnt pair.

---
 rtl/dii_package.sv | 10 +
 rtl/na_wb_pkg.sv | 24 ++
 rtl/noc_to_di_serializer.sv | 57 +++++
 rtl/na_read_wb.sv | 223 ++++++++++++++++++++++
 tb/tb_na_read_wb.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dii_package.sv
// Debug-interconnect flit type shared by every DI producer and consumer.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/na_wb_pkg.sv
// NoC adapter Wishbone address map, DI error fill word and read-path state type.
package na_wb_pkg;

  localparam logic [31:0] NA_WB_EP_STRIDE  = 32'h0000_2000;
  localparam logic [31:0] NA_WB_STATUS_OFS = 32'h0000_0000;
  localparam logic [31:0] NA_WB_DATA_OFS   = 32'h0000_0004;
  localparam logic [15:0] NA_DI_ERR_FILL   = 16'hDEAD;

  typedef enum logic [2:0] {
    NA_RD_IDLE,
    NA_RD_WAIT_GNT,
    NA_RD_STATUS,
    NA_RD_HDR,
    NA_RD_DATA,
    NA_RD_HI,
    NA_RD_LO,
    NA_RD_FILL
  } na_read_state_t;

  function automatic logic [31:0] na_wb_addr(input logic [7:0] ep, input logic [31:0] ofs);
    return (32'(ep) * NA_WB_EP_STRIDE) + ofs;
  endfunction

endpackage

// File: rtl/noc_to_di_serializer.sv
// Splits a 32-bit NoC word into two 16-bit DI flits (high half first) and
// also presents single header / error-fill flits; output is fully registered.
module noc_to_di_serializer
  import dii_package::*;
  import na_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_hdr,
  input  logic [15:0] hdr_data,
  input  logic        load_word,
  input  logic [31:0] word_data,
  input  logic        word_last,
  input  logic        load_fill,
  input  logic        out_flit_ready,
  output dii_flit     out_flit,
  output logic        flit_accept
);

  dii_flit     flit_r;
  logic [15:0] lo_hold_r;
  logic        lo_pend_r;
  logic        lo_last_r;

  assign flit_accept = flit_r.valid & out_flit_ready;
  assign out_flit    = flit_r;

  // Output flit register; the low half waits in lo_hold_r until the high half is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_r    <= '0;
      lo_hold_r <= 16'h0000;
      lo_pend_r <= 1'b0;
      lo_last_r <= 1'b0;
    end else if (load_hdr) begin
      flit_r    <= {1'b1, 1'b0, hdr_data};
      lo_pend_r <= 1'b0;
    end else if (load_fill) begin
      flit_r    <= {1'b1, 1'b1, NA_DI_ERR_FILL};
      lo_pend_r <= 1'b0;
    end else if (load_word) begin
      flit_r    <= {1'b1, 1'b0, word_data[31:16]};
      lo_hold_r <= word_data[15:0];
      lo_last_r <= word_last;
      lo_pend_r <= 1'b1;
    end else if (flit_accept) begin
      if (lo_pend_r) begin
        flit_r    <= {1'b1, lo_last_r, lo_hold_r};
        lo_pend_r <= 1'b0;
      end else begin
        flit_r.valid <= 1'b0;
        flit_r.last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/na_read_wb.sv
// NoC adapter egress: polls NI endpoints over Wishbone and emits packets as DI flits.
// Optional Wishbone watchdog enabled by defining NA_READ_WB_TIMEOUT_EN.
module na_read_wb
  import dii_package::*;
  import na_wb_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH    = 32,
  parameter int DI_FLIT_WIDTH     = 16,
  parameter int MAX_NOC_PKT_LEN   = 10,
  parameter int NUM_BE_ENDPOINTS  = 1,
  parameter int NUM_TDM_ENDPOINTS = 1,
  parameter int TIMEOUT_CYCLES    = 255
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      req,
  input  logic                      gnt,
  output dii_flit                   out_flit,
  input  logic                      out_flit_ready,
  output logic [31:0]               wb_adr_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic [NOC_FLIT_WIDTH-1:0] wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  output logic                      err_o
);

  localparam int                    NUM_EP  = NUM_BE_ENDPOINTS + NUM_TDM_ENDPOINTS;
  localparam logic [7:0]            LAST_EP = 8'(NUM_EP - 1);
  localparam logic [NOC_FLIT_WIDTH-1:0] MAX_LEN = NOC_FLIT_WIDTH'(MAX_NOC_PKT_LEN);

  na_read_state_t state_r, state_nxt;
  logic        req_r, req_nxt;
  logic        cyc_r, cyc_nxt;
  logic [31:0] adr_r, adr_nxt;
  logic        err_r, err_nxt;
  logic [7:0]  ep_idx_r, ep_nxt, ep_inc_s;
  logic [7:0]  remain_r, remain_nxt;
  logic        load_hdr_s, load_word_s, load_fill_s, flit_accept_s;
  logic        tmo_s, ack_s, berr_s;
  logic [DI_FLIT_WIDTH-1:0] hdr_s;

`ifdef NA_READ_WB_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Watchdog counts cycles of an outstanding Wishbone access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (!cyc_r || wb_ack_i || wb_err_i || tmo_s) begin
      tmo_cnt_r <= 8'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end
  end

  assign tmo_s = cyc_r && (tmo_cnt_r == 8'(TIMEOUT_CYCLES));
`else
  assign tmo_s = 1'b0;
`endif

  assign ack_s    = cyc_r & wb_ack_i;
  assign berr_s   = cyc_r & (wb_err_i | tmo_s);
  assign ep_inc_s = (ep_idx_r == LAST_EP) ? 8'd0 : ep_idx_r + 8'd1;
  assign hdr_s    = {8'h00, ep_idx_r};

  // State and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= NA_RD_IDLE;
      req_r    <= 1'b0;
      cyc_r    <= 1'b0;
      adr_r    <= 32'h0000_0000;
      err_r    <= 1'b0;
      ep_idx_r <= 8'd0;
      remain_r <= 8'd0;
    end else begin
      state_r  <= state_nxt;
      req_r    <= req_nxt;
      cyc_r    <= cyc_nxt;
      adr_r    <= adr_nxt;
      err_r    <= err_nxt;
      ep_idx_r <= ep_nxt;
      remain_r <= remain_nxt;
    end
  end

  // Next-state logic; req stays up from grant until the packet is finished.
  always_comb begin
    state_nxt   = state_r;
    req_nxt     = req_r;
    cyc_nxt     = cyc_r;
    adr_nxt     = adr_r;
    err_nxt     = err_r;
    ep_nxt      = ep_idx_r;
    remain_nxt  = remain_r;
    load_hdr_s  = 1'b0;
    load_word_s = 1'b0;
    load_fill_s = 1'b0;
    case (state_r)
      NA_RD_IDLE: begin
        if (enable) begin
          req_nxt   = 1'b1;
          state_nxt = NA_RD_WAIT_GNT;
        end else begin
          req_nxt   = 1'b0;
        end
      end
      NA_RD_WAIT_GNT: begin
        if (gnt) begin
          cyc_nxt   = 1'b1;
          adr_nxt   = na_wb_addr(ep_idx_r, NA_WB_STATUS_OFS);
          state_nxt = NA_RD_STATUS;
        end else begin
          req_nxt   = 1'b1;
        end
      end
      NA_RD_STATUS: begin
        if (berr_s || (ack_s && (wb_dat_i > MAX_LEN))) begin
          cyc_nxt   = 1'b0;
          err_nxt   = 1'b1;
          ep_nxt    = ep_inc_s;
          req_nxt   = 1'b0;
          state_nxt = NA_RD_IDLE;
        end else if (ack_s && (wb_dat_i == '0)) begin
          cyc_nxt   = 1'b0;
          ep_nxt    = ep_inc_s;
          req_nxt   = 1'b0;
          state_nxt = NA_RD_IDLE;
        end else if (ack_s) begin
          cyc_nxt    = 1'b0;
          remain_nxt = wb_dat_i[7:0];
          load_hdr_s = 1'b1;
          state_nxt  = NA_RD_HDR;
        end else begin
          cyc_nxt    = 1'b1;
        end
      end
      NA_RD_HDR: begin
        if (flit_accept_s) begin
          cyc_nxt   = 1'b1;
          adr_nxt   = na_wb_addr(ep_idx_r, NA_WB_DATA_OFS);
          state_nxt = NA_RD_DATA;
        end else begin
          state_nxt = NA_RD_HDR;
        end
      end
      NA_RD_DATA: begin
        if (berr_s) begin
          cyc_nxt     = 1'b0;
          err_nxt     = 1'b1;
          load_fill_s = 1'b1;
          state_nxt   = NA_RD_FILL;
        end else if (ack_s) begin
          cyc_nxt     = 1'b0;
          load_word_s = 1'b1;
          state_nxt   = NA_RD_HI;
        end else begin
          cyc_nxt     = 1'b1;
        end
      end
      NA_RD_HI: begin
        if (flit_accept_s) begin
          state_nxt = NA_RD_LO;
        end else begin
          state_nxt = NA_RD_HI;
        end
      end
      NA_RD_LO: begin
        if (flit_accept_s && (remain_r == 8'd1)) begin
          remain_nxt = 8'd0;
          ep_nxt     = ep_inc_s;
          req_nxt    = 1'b0;
          state_nxt  = NA_RD_IDLE;
        end else if (flit_accept_s) begin
          remain_nxt = remain_r - 8'd1;
          cyc_nxt    = 1'b1;
          adr_nxt    = na_wb_addr(ep_idx_r, NA_WB_DATA_OFS);
          state_nxt  = NA_RD_DATA;
        end else begin
          state_nxt  = NA_RD_LO;
        end
      end
      NA_RD_FILL: begin
        if (flit_accept_s) begin
          ep_nxt    = ep_inc_s;
          req_nxt   = 1'b0;
          state_nxt = NA_RD_IDLE;
        end else begin
          state_nxt = NA_RD_FILL;
        end
      end
      default: begin
        cyc_nxt   = 1'b0;
        req_nxt   = 1'b0;
        state_nxt = NA_RD_IDLE;
      end
    endcase
  end

  noc_to_di_serializer u_ser (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_hdr       (load_hdr_s),
    .hdr_data       (hdr_s),
    .load_word      (load_word_s),
    .word_data      (wb_dat_i),
    .word_last      (remain_r == 8'd1),
    .load_fill      (load_fill_s),
    .out_flit_ready (out_flit_ready),
    .out_flit       (out_flit),
    .flit_accept    (flit_accept_s)
  );

  assign req      = req_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;
  assign wb_adr_o = adr_r;
  assign err_o    = err_r;

endmodule

// File: tb/tb_na_read_wb.sv
// Directed + randomized bench for na_read_wb with a two-endpoint Wishbone slave model.
module tb_na_read_wb;
  import dii_package::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        req;
  logic        gnt = 1'b0;
  dii_flit     out_flit;
  logic        out_flit_ready = 1'b0;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  // slave model state: *_wr owned by main sequence, *_rd owned by slave
  logic [31:0] st_mem  [2][256];
  logic [31:0] dat_mem [2][256];
  int st_wr[2]  = '{0, 0};
  int st_rd[2]  = '{0, 0};
  int dat_wr[2] = '{0, 0};
  int dat_rd[2] = '{0, 0};
  bit err_arm = 1'b0;
  int err_ep = 0;
  int err_idx = 0;
  bit ack_hold = 1'b0;
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  // monitor state
  logic [15:0] obs_data [4096];
  logic        obs_last [4096];
  int obs_wr = 0;
  int obs_rd = 0;
  int overlap_cnt = 0;
  int cyc_low_cnt = 0;

  // reference model: per-endpoint packet lengths and words
  int          mdl_len [2][$];
  logic [31:0] mdl_w   [2][$];

  na_read_wb dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .gnt(gnt),
    .out_flit(out_flit), .out_flit_ready(out_flit_ready),
    .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Wishbone slave: answers one cycle after seeing a strobe
  initial forever begin
    int ep;
    @(posedge clk); #1;
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !ack_hold) begin
      ep = int'(wb_adr_o[13]);
      if (wb_adr_o[3:0] == 4'h0) begin
        if (st_rd[ep] < st_wr[ep]) begin
          wb_dat_i = st_mem[ep][st_rd[ep]];
          st_rd[ep]++;
        end else begin
          wb_dat_i = 32'h0;
        end
        wb_ack_i = 1'b1;
      end else begin
        if (err_arm && ep == err_ep && dat_rd[ep] == err_idx) begin
          wb_dat_i = 32'h0;
          wb_err_i = 1'b1;
        end else begin
          wb_dat_i = dat_mem[ep][dat_rd[ep]];
          wb_ack_i = 1'b1;
        end
        dat_rd[ep]++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  // grant follows request; ready is forced or random
  initial forever begin
    @(posedge clk); #2;
    gnt = req;
    out_flit_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // DI handshake capture and bus/flit overlap watch
  always @(negedge clk) begin
    if (out_flit.valid && out_flit_ready) begin
      obs_data[obs_wr] = out_flit.data;
      obs_last[obs_wr] = out_flit.last;
      obs_wr++;
    end
    if (out_flit.valid && wb_cyc_o) overlap_cnt++;
    if (!wb_cyc_o) cyc_low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input int ep, input logic [31:0] w);
    dat_mem[ep][dat_wr[ep]] = w;
    dat_wr[ep]++;
  endtask

  task automatic push_status(input int ep, input logic [31:0] s);
    st_mem[ep][st_wr[ep]] = s;
    st_wr[ep]++;
  endtask

  task automatic expect_flit(input logic [15:0] d, input logic l, input string tag);
    int n = 0;
    while (obs_rd >= obs_wr && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, " avail"}, 32'(obs_rd < obs_wr), 32'd1);
    if (obs_rd < obs_wr) begin
      chk({tag, " data"}, 32'(obs_data[obs_rd]), 32'(d));
      chk({tag, " last"}, 32'(obs_last[obs_rd]), 32'(l));
      obs_rd++;
    end
  endtask

  task automatic expect_req_low(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (!req) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic expect_next_poll(input logic [31:0] adr, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (wb_cyc_o) seen = 1'b1;
    end
    chk({tag, " cyc"}, 32'(seen), 32'd1);
    chk({tag, " adr"}, wb_adr_o, adr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int ep, len, hdr_ep, snap, npk;
    bit seen;
    logic [31:0] w;

    // reset state
    tick(3);
    chk("rst req", 32'(req), 32'd0);
    chk("rst cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst stb", 32'(wb_stb_o), 32'd0);
    chk("rst adr", wb_adr_o, 32'h0);
    chk("rst flit", 32'(out_flit), 32'h0);
    chk("rst err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    tick(4);
    chk("idle no req", 32'(req), 32'd0);
    enable = 1'b1;

    // two-word packet on ep0
    push_word(0, 32'h1111_2222);
    push_word(0, 32'h3333_4444);
    push_status(0, 32'd2);
    expect_flit(16'h0000, 1'b0, "t1 hdr");
    expect_flit(16'h1111, 1'b0, "t1 hi0");
    expect_flit(16'h2222, 1'b0, "t1 lo0");
    expect_flit(16'h3333, 1'b0, "t1 hi1");
    expect_flit(16'h4444, 1'b1, "t1 lo1");
    expect_req_low("t1 req drop");

    // ep1 packet, then polling wraps to ep0
    push_word(1, 32'hABCD_1234);
    push_status(1, 32'd1);
    expect_flit(16'h0001, 1'b0, "t2 hdr");
    expect_flit(16'hABCD, 1'b0, "t2 hi");
    expect_flit(16'h1234, 1'b1, "t2 lo");
    expect_next_poll(32'h0000_0000, "t2 wrap");

    // backpressure while the high half is presented
    push_word(0, 32'hCAFE_F00D);
    push_status(0, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (out_flit.valid && out_flit.data == 16'hCAFE) begin
        ready_force = 1'b0;
        seen = 1'b1;
      end
    end
    chk("t3 hi seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3 hold valid", 32'(out_flit.valid), 32'd1);
      chk("t3 hold data", 32'(out_flit.data), 32'h0000_CAFE);
      chk("t3 no wb", 32'(wb_cyc_o), 32'd0);
    end
    ready_force = 1'b1;
    expect_flit(16'h0000, 1'b0, "t3 hdr");
    expect_flit(16'hCAFE, 1'b0, "t3 hi");
    expect_flit(16'hF00D, 1'b1, "t3 lo");

    // randomized packets with random ready
    rand_ready = 1'b1;
    npk = 8;
    for (int p = 0; p < npk; p++) begin
      ep = $urandom_range(0, 1);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        w = $urandom;
        push_word(ep, w);
        mdl_w[ep].push_back(w);
      end
      mdl_len[ep].push_back(len);
      push_status(ep, 32'(len));
      tick($urandom_range(0, 20));
    end
    for (int p = 0; p < npk; p++) begin
      seen = 1'b0;
      for (int n = 0; n < 3000 && obs_rd >= obs_wr; n++) @(posedge clk);
      chk("rnd hdr avail", 32'(obs_rd < obs_wr), 32'd1);
      if (obs_rd >= obs_wr) break;
      hdr_ep = int'(obs_data[obs_rd][7:0]);
      chk("rnd hdr upper", 32'(obs_data[obs_rd][15:8]), 32'd0);
      chk("rnd hdr last", 32'(obs_last[obs_rd]), 32'd0);
      obs_rd++;
      chk("rnd hdr ep valid", 32'(hdr_ep < 2 && mdl_len[hdr_ep & 1].size() > 0), 32'd1);
      if (!(hdr_ep < 2 && mdl_len[hdr_ep & 1].size() > 0)) break;
      len = mdl_len[hdr_ep].pop_front();
      for (int k = 0; k < len; k++) begin
        w = mdl_w[hdr_ep].pop_front();
        expect_flit(w[31:16], 1'b0, "rnd hi");
        expect_flit(w[15:0], k == len - 1, "rnd lo");
      end
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    tick(10);

    // bus error on second DATA read of a 3-flit packet
    do_reset();
    chk("t4 err clear", 32'(err_o), 32'd0);
    err_ep = 0;
    err_idx = dat_wr[0] + 1;
    err_arm = 1'b1;
    push_word(0, 32'h5A5A_0F0F);
    push_word(0, 32'h0000_0000);
    push_status(0, 32'd3);
    expect_flit(16'h0000, 1'b0, "t4 hdr");
    expect_flit(16'h5A5A, 1'b0, "t4 hi0");
    expect_flit(16'h0F0F, 1'b0, "t4 lo0");
    expect_flit(16'hDEAD, 1'b1, "t4 fill");
    expect_req_low("t4 req drop");
    chk("t4 err set", 32'(err_o), 32'd1);
    err_arm = 1'b0;

    // oversize STATUS is an error and skips the endpoint
    do_reset();
    chk("t5 err clear", 32'(err_o), 32'd0);
    snap = obs_wr;
    push_status(0, 32'd11);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (err_o) seen = 1'b1;
    end
    chk("t5 err set", 32'(seen), 32'd1);
    expect_next_poll(32'h0000_2000, "t5 skip");
    tick(10);
    chk("t5 no flits", 32'(obs_wr - snap), 32'd0);

    // missing acknowledge
    do_reset();
    ack_hold = 1'b1;
    tick(20);
    chk("t6 cyc stuck", 32'(wb_cyc_o), 32'd1);
`ifdef NA_READ_WB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (!wb_cyc_o) seen = 1'b1;
    end
    chk("t6 timeout cyc drop", 32'(seen), 32'd1);
    chk("t6 timeout err", 32'(err_o), 32'd1);
`else
    snap = cyc_low_cnt;
    tick(300);
    chk("t6 cyc held", 32'(cyc_low_cnt - snap), 32'd0);
    chk("t6 no err", 32'(err_o), 32'd0);
`endif
    ack_hold = 1'b0;
    push_word(1, 32'h7777_8888);
    push_status(1, 32'd1);
    expect_flit(16'h0001, 1'b0, "t6 hdr");
    expect_flit(16'h7777, 1'b0, "t6 hi");
    expect_flit(16'h8888, 1'b1, "t6 lo");

    chk("no wb while flit pending", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
